// File: rtl/pbit_sample_decoder.sv
// pbit_sample_decoder: start/done measurement engine for the 4-bit p-bit adder.
// After an accepted start it drops BURN_IN clocks so the p-bit network can settle.
// It then samples a/b/sum/overflow for exactly steps_q clocks.
// Each bit is decoded by strict majority, and the engine counts the samples
// where a + b equals {ovf, sum}.
module pbit_sample_decoder #(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 16,
  parameter int BURN_IN = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] steps,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] s_in,
  input  logic             ovf_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a_dec,
  output logic [WIDTH-1:0] b_dec,
  output logic [WIDTH-1:0] s_dec,
  output logic             ovf_dec,
  output logic [CNT_W-1:0] consistent_count
);

  // One counter each for every a, b and sum bit, plus one for overflow.
  localparam int NB = 3*WIDTH + 1;
  // Width of the burn-in counter, which runs from 0 to BURN_IN-1.
  localparam int BW = (BURN_IN > 1) ? $clog2(BURN_IN) : 1;
  localparam logic [BW-1:0] BURN_LAST = (BURN_IN > 0) ? BW'(BURN_IN - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BURN = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] steps_q;
  logic [BW-1:0]    burn_q;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] cons_q;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [NB-1:0]    dec_bit;
  logic [NB-1:0]    dec_q;
  logic [CNT_W-1:0] cons_out_q;

  logic             start_ok;
  logic             burn_last;
  logic             acc_full;
  logic             sample_en;
  logic             clear_en;
  logic [WIDTH:0]   sum_w;
  logic             consistent;
  logic [NB-1:0]    smp;

  // A start request is honoured only when it asks for a non-empty run.
  assign start_ok   = start && (steps != '0);
  assign burn_last  = (burn_q == BURN_LAST);
  // acc_q counts samples already taken; once it reaches steps_q, one extra
  // ACC cycle registers the decoded results before DONE.
  assign acc_full   = (acc_q == steps_q);
  assign sample_en  = (state_q == S_ACC) && !acc_full;
  assign clear_en   = (state_q == S_IDLE) && start_ok;
  assign smp        = {ovf_in, s_in, b_in, a_in};
  // The sum is compared at WIDTH+1 bits, so the carry must match ovf_in.
  assign sum_w      = {1'b0, a_in} + {1'b0, b_in};
  assign consistent = (sum_w == {ovf_in, s_in});

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_ok) state_d = (BURN_IN == 0) ? S_ACC : S_BURN;
      S_BURN: if (burn_last) state_d = S_ACC;
      S_ACC:  if (acc_full) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded straight from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_BURN, S_ACC: busy = 1'b1;
      S_DONE:        done = 1'b1;
      default: ;
    endcase
  end

  // Run control: steps capture, burn-in counter, sample counter, consistency counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      steps_q <= '0;
      burn_q  <= '0;
      acc_q   <= '0;
      cons_q  <= '0;
    end else if (clear_en) begin
      steps_q <= steps;
      burn_q  <= '0;
      acc_q   <= '0;
      cons_q  <= '0;
    end else if (state_q == S_BURN) begin
      burn_q <= burn_q + BW'(1);
    end else if (sample_en) begin
      acc_q <= acc_q + CNT_W'(1);
      if (consistent) cons_q <= cons_q + CNT_W'(1);
    end
  end

  // Per-bit ones counters and strict-majority decode (ties decode to 0)
  for (genvar gi = 0; gi < NB; gi++) begin : g_bit
    // Count the cycles in which this p-bit was sampled high
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                     cnt_q[gi] <= '0;
      else if (clear_en)             cnt_q[gi] <= '0;
      else if (sample_en && smp[gi]) cnt_q[gi] <= cnt_q[gi] + CNT_W'(1);
    end
    assign dec_bit[gi] = {cnt_q[gi], 1'b0} > {1'b0, steps_q};
  end

  // Latch the results on the cycle that enters DONE; they are held until the next run ends
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_q      <= '0;
      cons_out_q <= '0;
    end else if ((state_q == S_ACC) && acc_full) begin
      dec_q      <= dec_bit;
      cons_out_q <= cons_q;
    end
  end

  assign a_dec            = dec_q[WIDTH-1:0];
  assign b_dec            = dec_q[2*WIDTH-1:WIDTH];
  assign s_dec            = dec_q[3*WIDTH-1:2*WIDTH];
  assign ovf_dec          = dec_q[3*WIDTH];
  assign consistent_count = cons_out_q;

endmodule

// File: tb/tb_pbit_sample_decoder.sv
// Directed bench for pbit_sample_decoder (WIDTH=4, CNT_W=16, BURN_IN=16).
module tb_pbit_sample_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] steps;
  logic [3:0]  a_in, b_in, s_in;
  logic        ovf_in;
  logic        busy, done;
  logic [3:0]  a_dec, b_dec, s_dec;
  logic        ovf_dec;
  logic [15:0] consistent_count;

  int checks = 0;
  int errors = 0;

  pbit_sample_decoder #(.WIDTH(4), .CNT_W(16), .BURN_IN(16)) dut (
    .clk(clk), .reset(reset), .start(start), .steps(steps),
    .a_in(a_in), .b_in(b_in), .s_in(s_in), .ovf_in(ovf_in),
    .busy(busy), .done(done), .a_dec(a_dec), .b_dec(b_dec), .s_dec(s_dec),
    .ovf_dec(ovf_dec), .consistent_count(consistent_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                         input logic [3:0] es, input logic eo, input logic [15:0] ec);
    chk({tag, ".a_dec"}, a_dec, ea);
    chk({tag, ".b_dec"}, b_dec, eb);
    chk({tag, ".s_dec"}, s_dec, es);
    chk({tag, ".ovf_dec"}, ovf_dec, eo);
    chk({tag, ".cons"}, consistent_count, ec);
  endtask

  // mode 0: constant inputs, 1: s_in[0] toggles every clock, 2: start pulses during BURN and ACC
  task automatic run(input string tag, input logic [15:0] st, input int mode, input int exp_lat);
    int n;
    int limit;
    start = 1'b1;
    steps = st;
    tick();                     // accepting edge k
    start = 1'b0;
    steps = 16'd7;              // later changes to steps must be ignored
    chk({tag, ".busy_start"}, busy, 1);
    if (mode == 1) s_in[0] = ~s_in[0];
    n = 0;
    limit = exp_lat + 10;
    while (n < limit) begin
      tick();
      n++;
      if (done) break;
      if (mode == 1) s_in[0] = ~s_in[0];
      if (mode == 2) begin
        start = (n == 5 || n == 25);
        steps = 16'd3;
      end
    end
    start = 1'b0;
    chk({tag, ".latency"}, n, exp_lat);
    chk({tag, ".busy_at_done"}, busy, 0);
    tick();
    chk({tag, ".done_one_cycle"}, done, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; steps = '0;
    a_in = '0; b_in = '0; s_in = '0; ovf_in = 1'b0;
    tick(); tick();
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk_out("reset", 4'd0, 4'd0, 4'd0, 1'b0, 16'd0);
    reset = 1'b0;
    tick();

    // 1: constant consistent inputs, 100 samples
    a_in = 4'd1; b_in = 4'd7; s_in = 4'd8; ovf_in = 1'b0;
    run("t1", 16'd100, 0, 117);
    chk_out("t1", 4'd1, 4'd7, 4'd8, 1'b0, 16'd100);

    // 2: s_in[0] alternates 1,0,1,0 over 4 samples -> tie decodes 0, 2 consistent
    a_in = '0; b_in = '0; s_in = '0; ovf_in = 1'b0;
    run("t2", 16'd4, 1, 21);
    chk_out("t2", 4'd0, 4'd0, 4'd0, 1'b0, 16'd2);

    // 2b: same pattern over 3 samples -> 1,0,1 is a majority of ones, 1 consistent
    s_in = '0;
    run("t2b", 16'd3, 1, 20);
    chk_out("t2b", 4'd0, 4'd0, 4'd1, 1'b0, 16'd1);

    // 3: start with steps=0 is ignored
    s_in = '0;
    start = 1'b1; steps = 16'd0;
    tick();
    start = 1'b0;
    chk("t3.busy", busy, 0);
    tick();
    chk("t3.busy2", busy, 0);
    chk("t3.done", done, 0);
    chk_out("t3", 4'd0, 4'd0, 4'd1, 1'b0, 16'd1);

    // 4: asynchronous reset in the middle of ACC of a 50-sample run
    a_in = 4'd1; b_in = 4'd7; s_in = 4'd8; ovf_in = 1'b0;
    run("t4pre", 16'd10, 0, 27);
    chk_out("t4pre", 4'd1, 4'd7, 4'd8, 1'b0, 16'd10);
    start = 1'b1; steps = 16'd50;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("t4.busy_mid", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("t4.busy", busy, 0);
    chk("t4.done", done, 0);
    chk_out("t4", 4'd0, 4'd0, 4'd0, 1'b0, 16'd0);
    tick();
    reset = 1'b0;
    a_in = 4'd3; b_in = 4'd5; s_in = 4'd8; ovf_in = 1'b0;
    run("t4post", 16'd10, 0, 27);
    chk_out("t4post", 4'd3, 4'd5, 4'd8, 1'b0, 16'd10);

    // 5: start pulses during BURN and ACC are ignored
    a_in = 4'd2; b_in = 4'd9; s_in = 4'd11; ovf_in = 1'b0;
    run("t5", 16'd20, 2, 37);
    chk_out("t5", 4'd2, 4'd9, 4'd11, 1'b0, 16'd20);
    a_in = 4'd6; b_in = 4'd6; s_in = 4'd13; ovf_in = 1'b0;
    run("t5b", 16'd5, 0, 22);
    chk_out("t5b", 4'd6, 4'd6, 4'd13, 1'b0, 16'd0);

    // 6: maximum step count with all inputs high, no wrap
    a_in = 4'd15; b_in = 4'd15; s_in = 4'd15; ovf_in = 1'b1;
    run("t6", 16'd65535, 0, 65552);
    chk_out("t6", 4'd15, 4'd15, 4'd15, 1'b1, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
